// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind scoring stage: default code geometry,
// count width, the packed code type and the scorer FSM state encoding.
package mastermind_pkg;

    localparam int NUM_PEGS = 4;
    localparam int COLOR_W  = 2;
    localparam int CNT_W    = $clog2(NUM_PEGS + 1);

    typedef logic [NUM_PEGS*COLOR_W-1:0] code_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        COLOR = 2'd2,
        DONE  = 2'd3
    } scorer_state_t;

endpackage

// File: rtl/mastermind_scorer_color_counter.sv
// color_counter: purely combinational count of how many pegs of a packed
// code hold a given colour. Used once for the guess and once for the solution.
module color_counter #(
    parameter int NUM_PEGS = mastermind_pkg::NUM_PEGS,
    parameter int COLOR_W  = mastermind_pkg::COLOR_W,
    localparam int CW      = $clog2(NUM_PEGS + 1)
) (
    input  logic [NUM_PEGS*COLOR_W-1:0] code_i,
    input  logic [COLOR_W-1:0]          color_i,
    output logic [CW-1:0]               count_o
);

    logic [NUM_PEGS-1:0] hit;

    for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_hit
        assign hit[gi] = (code_i[gi*COLOR_W +: COLOR_W] == color_i);
    end

    // Population count of the per-peg colour hits.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            count_o = count_o + CW'(hit[i]);
        end
    end

endmodule

// File: rtl/mastermind_scorer.sv
// mastermind_scorer: latches a guess/solution pair on submit and scores it
// over several cycles (one exact-match cycle, then one cycle per colour
// accumulating min(guess count, solution count)). Tracks tries and victory.
// Optional try limit compiled in with macro MASTERMIND_TRY_LIMIT_EN; without
// it game_over is constant 0.
module mastermind_scorer #(
    parameter int NUM_PEGS  = mastermind_pkg::NUM_PEGS,
    parameter int COLOR_W   = mastermind_pkg::COLOR_W,
    parameter int MAX_TRIES = 10,
    localparam int CW       = $clog2(NUM_PEGS + 1),
    localparam int CODE_W   = NUM_PEGS * COLOR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              submit,
    input  logic              new_game,
    input  logic [CODE_W-1:0] guess,
    input  logic [CODE_W-1:0] sol,
    output logic              busy,
    output logic              score_valid,
    output logic [CW-1:0]     exact_cnt,
    output logic [CW-1:0]     partial_cnt,
    output logic [5:0]        tries,
    output logic              victory,
    output logic              game_over
);

    import mastermind_pkg::*;

    localparam logic [COLOR_W-1:0] LAST_COLOR = '1;

    scorer_state_t     state_q, state_d;
    logic [CODE_W-1:0] guess_q, sol_q;
    logic [COLOR_W-1:0] color_q;
    logic [CW-1:0]     exact_q;
    logic [CW-1:0]     acc_q;
    logic [CW-1:0]     exact_cnt_q, partial_cnt_q;
    logic [5:0]        tries_q;
    logic              victory_q;
    logic              game_over_q;

    logic [CW-1:0]     guess_color_cnt, sol_color_cnt;
    logic [CW-1:0]     min_cnt;
    logic [CW-1:0]     acc_sum;
    logic [CW-1:0]     exact_now;
    logic [NUM_PEGS-1:0] peg_match;
    logic [5:0]        tries_inc;
    logic              win;
    logic              accept;

    color_counter #(.NUM_PEGS(NUM_PEGS), .COLOR_W(COLOR_W)) u_guess_cnt (
        .code_i  (guess_q),
        .color_i (color_q),
        .count_o (guess_color_cnt)
    );

    color_counter #(.NUM_PEGS(NUM_PEGS), .COLOR_W(COLOR_W)) u_sol_cnt (
        .code_i  (sol_q),
        .color_i (color_q),
        .count_o (sol_color_cnt)
    );

    for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_match
        assign peg_match[gi] = (guess_q[gi*COLOR_W +: COLOR_W] == sol_q[gi*COLOR_W +: COLOR_W]);
    end

    // Exact-match count of the latched pair.
    always_comb begin
        exact_now = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            exact_now = exact_now + CW'(peg_match[i]);
        end
    end

    assign min_cnt   = (guess_color_cnt < sol_color_cnt) ? guess_color_cnt : sol_color_cnt;
    assign acc_sum   = acc_q + min_cnt;
    assign tries_inc = (tries_q == 6'd63) ? 6'd63 : tries_q + 6'd1;
    assign win       = (exact_cnt_q == CW'(NUM_PEGS));
    assign accept    = submit && !victory_q && !game_over_q;

    // Next-state logic; new_game aborts any score and wins over submit.
    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = EXACT;
                EXACT:   state_d = COLOR;
                COLOR:   if (color_q == LAST_COLOR) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and scoring datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            guess_q       <= '0;
            sol_q         <= '0;
            color_q       <= '0;
            exact_q       <= '0;
            acc_q         <= '0;
            exact_cnt_q   <= '0;
            partial_cnt_q <= '0;
            tries_q       <= '0;
            victory_q     <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (new_game) begin
                color_q       <= '0;
                acc_q         <= '0;
                exact_cnt_q   <= '0;
                partial_cnt_q <= '0;
                tries_q       <= '0;
                victory_q     <= 1'b0;
                game_over_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            guess_q <= guess;
                            sol_q   <= sol;
                        end
                    end
                    EXACT: begin
                        exact_q <= exact_now;
                        acc_q   <= '0;
                        color_q <= '0;
                    end
                    COLOR: begin
                        acc_q   <= acc_sum;
                        color_q <= color_q + 1'b1;
                        if (color_q == LAST_COLOR) begin
                            // Sum of mins always covers the exact matches, so no underflow.
                            exact_cnt_q   <= exact_q;
                            partial_cnt_q <= acc_sum - exact_q;
                        end
                    end
                    DONE: begin
                        tries_q <= tries_inc;
                        if (win) victory_q <= 1'b1;
`ifdef MASTERMIND_TRY_LIMIT_EN
                        if ((tries_inc == 6'(MAX_TRIES)) && !win) game_over_q <= 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign score_valid = (state_q == DONE);
    assign exact_cnt   = exact_cnt_q;
    assign partial_cnt = partial_cnt_q;
    assign tries       = tries_q;
    assign victory     = victory_q;
`ifdef MASTERMIND_TRY_LIMIT_EN
    assign game_over   = game_over_q;
`else
    assign game_over   = 1'b0;
`endif

endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed bench for mastermind_scorer: a table of scored guesses plus
// hand-written sequences for busy-submit, reset/new_game aborts and the
// optional try limit (MASTERMIND_TRY_LIMIT_EN).
module tb_mastermind_scorer;
    import mastermind_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       submit;
    logic       new_game;
    code_t      guess;
    code_t      sol;
    logic       busy;
    logic       score_valid;
    logic [2:0] exact_cnt;
    logic [2:0] partial_cnt;
    logic [5:0] tries;
    logic       victory;
    logic       game_over;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mastermind_scorer #(.NUM_PEGS(4), .COLOR_W(2), .MAX_TRIES(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .submit      (submit),
        .new_game    (new_game),
        .guess       (guess),
        .sol         (sol),
        .busy        (busy),
        .score_valid (score_valid),
        .exact_cnt   (exact_cnt),
        .partial_cnt (partial_cnt),
        .tries       (tries),
        .victory     (victory),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g;
        logic [7:0] s;
        int         ex;
        int         pa;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    // Submit at the current negedge; return at the negedge where score_valid is seen.
    task automatic do_score(input logic [7:0] g, input logic [7:0] s, output int lat);
        guess  = g;
        sol    = s;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        lat = 1;
        while (!score_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic watch(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (score_valid) pulses++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int pulses;
        int ex_seen;
        int pa_seen;

        vecs[0] = '{8'b00_01_10_11, 8'b00_01_10_11, 4, 0};
        vecs[1] = '{8'b11_10_01_00, 8'b00_01_10_11, 0, 4};
        vecs[2] = '{8'b01_00_11_11, 8'b00_00_01_01, 1, 1};
        vecs[3] = '{8'b00_00_00_00, 8'b11_11_11_11, 0, 0};
        vecs[4] = '{8'b01_01_10_10, 8'b10_10_01_01, 0, 4};
        vecs[5] = '{8'b00_00_00_00, 8'b00_11_11_11, 1, 0};
        vecs[6] = '{8'b11_00_11_00, 8'b11_11_00_00, 2, 2};
        vecs[7] = '{8'b10_10_10_01, 8'b01_10_00_10, 1, 2};

        rst = 1'b1; submit = 1'b0; new_game = 1'b0; guess = '0; sol = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_valid", score_valid, 0);
        chk("reset_exact", exact_cnt, 0);
        chk("reset_partial", partial_cnt, 0);
        chk("reset_tries", tries, 0);
        chk("reset_victory", victory, 0);
        chk("reset_game_over", game_over, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table of scored guesses, each in a fresh game.
        for (int v = 0; v < 8; v++) begin
            pulse_new_game();
            do_score(vecs[v].g, vecs[v].s, lat);
            chk($sformatf("vec%0d_latency", v), lat, 6);
            chk($sformatf("vec%0d_exact", v), exact_cnt, vecs[v].ex);
            chk($sformatf("vec%0d_partial", v), partial_cnt, vecs[v].pa);
            @(negedge clk);
            chk($sformatf("vec%0d_tries", v), tries, 1);
            chk($sformatf("vec%0d_victory", v), victory, (vecs[v].ex == 4) ? 1 : 0);
            chk($sformatf("vec%0d_busy", v), busy, 0);
            $display("vec%0d guess=%b sol=%b exact=%0d partial=%0d tries=%0d", v,
                     vecs[v].g, vecs[v].s, exact_cnt, partial_cnt, tries);
        end

        // Win, then a further submit is ignored.
        pulse_new_game();
        do_score(8'b00_01_10_11, 8'b00_01_10_11, lat);
        @(negedge clk);
        chk("win_victory", victory, 1);
        guess = 8'b11_11_11_11; submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        chk("win_resubmit_busy", busy, 0);
        watch(10, pulses);
        chk("win_resubmit_pulses", pulses, 0);
        chk("win_resubmit_tries", tries, 1);
        $display("seq win: victory=%0d tries=%0d", victory, tries);

        // Submit while busy is dropped; latched guess is scored.
        pulse_new_game();
        guess = 8'b01_00_11_11; sol = 8'b00_00_01_01; submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        @(negedge clk);
        guess = 8'b00_00_01_01; submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        pulses = 0; ex_seen = -1; pa_seen = -1;
        for (int i = 0; i < 12; i++) begin
            if (score_valid) begin
                pulses++;
                ex_seen = exact_cnt;
                pa_seen = partial_cnt;
            end
            @(negedge clk);
        end
        chk("busy_submit_pulses", pulses, 1);
        chk("busy_submit_exact", ex_seen, 1);
        chk("busy_submit_partial", pa_seen, 1);
        chk("busy_submit_tries", tries, 1);
        chk("busy_submit_victory", victory, 0);
        $display("seq busy-submit: pulses=%0d exact=%0d partial=%0d tries=%0d", pulses, ex_seen, pa_seen, tries);

        // Asynchronous reset during COLOR.
        guess = 8'b11_10_01_00; sol = 8'b00_01_10_11; submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_tries", tries, 0);
        chk("rst_mid_exact", exact_cnt, 0);
        chk("rst_mid_partial", partial_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        watch(10, pulses);
        chk("rst_mid_pulses", pulses, 0);
        do_score(8'b11_10_01_00, 8'b00_01_10_11, lat);
        chk("rst_after_latency", lat, 6);
        chk("rst_after_partial", partial_cnt, 4);
        @(negedge clk);
        chk("rst_after_tries", tries, 1);
        $display("seq rst-abort: tries=%0d partial=%0d", tries, partial_cnt);

        // new_game during COLOR.
        guess = 8'b01_00_11_11; sol = 8'b00_00_01_01; submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        repeat (2) @(negedge clk);
        pulse_new_game();
        chk("ng_mid_busy", busy, 0);
        chk("ng_mid_tries", tries, 0);
        chk("ng_mid_partial", partial_cnt, 0);
        watch(10, pulses);
        chk("ng_mid_pulses", pulses, 0);
        do_score(8'b01_00_11_11, 8'b00_00_01_01, lat);
        chk("ng_after_exact", exact_cnt, 1);
        @(negedge clk);
        chk("ng_after_tries", tries, 1);
        $display("seq new_game-abort: tries=%0d exact=%0d", tries, exact_cnt);

        // Try limit.
        pulse_new_game();
`ifdef MASTERMIND_TRY_LIMIT_EN
        for (int k = 1; k <= 3; k++) begin
            do_score(8'b11_10_01_00, 8'b00_01_10_11, lat);
            @(negedge clk);
            chk($sformatf("limit_game_over_%0d", k), game_over, (k == 3) ? 1 : 0);
        end
        chk("limit_tries", tries, 3);
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        watch(10, pulses);
        chk("limit_ignored_pulses", pulses, 0);
        chk("limit_ignored_tries", tries, 3);
        pulse_new_game();
        chk("limit_cleared_game_over", game_over, 0);
        chk("limit_cleared_tries", tries, 0);
        $display("seq try-limit: game_over=%0d tries=%0d", game_over, tries);
`else
        for (int k = 1; k <= 64; k++) begin
            do_score(8'b11_10_01_00, 8'b00_01_10_11, lat);
            @(negedge clk);
            if (k == 4) begin
                chk("nolimit_game_over", game_over, 0);
                chk("nolimit_tries4", tries, 4);
            end
        end
        chk("sat_tries", tries, 63);
        chk("sat_game_over", game_over, 0);
        $display("seq saturation: tries=%0d game_over=%0d", tries, game_over);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
Scoring stage that sits downstream of the guess-entry and solution LFSR logic in the DE1_SoC Mastermind game.
- On a submit pulse it latches the packed guess and the solution.
- It computes exact-match (right colour, right place) and partial-match (right colour, wrong place) counts with a multi-cycle FSM, one colour per cycle.
- It tracks tries and victory, and reports a one-cycle score_valid strobe to the LED/HEX display logic.

Parameters:
- NUM_PEGS, 4, number of peg positions in a code.
- COLOR_W, 2, bits per peg; colours are 0 .. 2^COLOR_W-1.
- MAX_TRIES, 10, try limit used only when the optional feature is compiled in.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- submit  in  1  single-cycle pulse; request scoring of the current guess.
- new_game  in  1  synchronous clear of tries, victory, counts and game_over.
- guess  in  NUM_PEGS*COLOR_W  packed guess, peg i at bits [i*COLOR_W +: COLOR_W].
- sol  in  NUM_PEGS*COLOR_W  packed solution, same packing.
- busy  out  1  high from the cycle after an accepted submit until score_valid deasserts.
- score_valid  out  1  one-cycle strobe; exact_cnt and partial_cnt are valid and stable.
- exact_cnt  out  $clog2(NUM_PEGS+1)  right colour, right place.
- partial_cnt  out  $clog2(NUM_PEGS+1)  right colour, wrong place.
- tries  out  6  accepted submissions since reset or new_game; saturates at 63.
- victory  out  1  sticky; set when exact_cnt == NUM_PEGS.
- game_over  out  1  see Optional Feature; tied 0 when the feature is absent.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; internal latches and accumulators 0.
- States: IDLE, EXACT, COLOR, DONE.
- IDLE:
  - A submit is accepted only if victory=0 and game_over=0.
  - When accepted, latch guess and sol into internal registers, then go to EXACT.
  - Otherwise the submit is ignored and no state changes.
- EXACT (1 cycle):
  - Register exact = number of pegs i with guess_i == sol_i.
  - Clear the min-sum accumulator and set colour index c=0.
  - Go to COLOR.
- COLOR (2^COLOR_W cycles, one colour per cycle):
  - Each cycle: acc += min(count of c in latched guess, count of c in latched sol); then c++.
  - After c = 2^COLOR_W-1, go to DONE.
  - acc has width $clog2(NUM_PEGS+1); it cannot overflow because the sum of mins is at most NUM_PEGS.
- On the edge leaving the last COLOR cycle:
  - exact_cnt <= exact.
  - partial_cnt <= acc - exact; this is never negative, since exact <= acc.
- DONE (1 cycle):
  - score_valid=1.
  - On the edge leaving DONE: tries <= tries+1 (saturating); victory <= 1 if exact_cnt == NUM_PEGS.
  - Go to IDLE.
- Latency: submit sampled at edge t means score_valid is high during cycle t+2^COLOR_W+2. With defaults, score_valid is high in the 6th cycle after the submit edge.
- busy is high in EXACT, COLOR and DONE.
- submit while busy is ignored, not queued. Input changes while busy have no effect, because the latched copies are used.
- exact_cnt and partial_cnt hold their last values until the next score completes.
- new_game has priority in any state:
  - Aborts any in-progress score and returns to IDLE.
  - Clears tries, victory, game_over, exact_cnt and partial_cnt.
  - A submit in the same cycle as new_game is dropped.
- rst mid-operation: immediate return to IDLE with all outputs 0; no score_valid is produced.

Optional Feature:
- Macro: MASTERMIND_TRY_LIMIT_EN.
- Defined:
  - On the edge leaving DONE, game_over <= 1 if the incremented tries equals MAX_TRIES and victory is not being set.
  - While game_over=1, submits are ignored; only new_game or rst clears game_over.
- Undefined: game_over is constant 0, and submits are limited only by victory.

Decomposition:
- Shared package mastermind_pkg holds:
  - NUM_PEGS and COLOR_W defaults.
  - CNT_W = $clog2(NUM_PEGS+1).
  - typedef code_t, a packed [NUM_PEGS*COLOR_W-1:0] vector.
  - typedef enum scorer_state_t {IDLE, EXACT, COLOR, DONE}.
- One sub-module, color_counter: takes a code_t and a colour index and returns the CNT_W-bit occurrence count. It is instantiated twice, once for the guess and once for the solution.

Test Plan:
1. sol=8'b00_01_10_11, guess=8'b00_01_10_11, submit -> score_valid exactly 6 cycles later; exact_cnt=4, partial_cnt=0; victory=1; tries=1; a further submit is ignored (tries stays 1).
2. sol=8'b00_01_10_11, guess=8'b11_10_01_00 -> exact_cnt=0, partial_cnt=4, victory=0.
3. sol=8'b00_00_01_01, guess=8'b01_00_11_11 -> exact_cnt=1, partial_cnt=1.
4. Submit, then change guess and pulse submit again 2 cycles later while busy -> a single score_valid reflecting the first guess; tries increments by 1 only.
5. Assert rst during COLOR, then release; separately, pulse new_game during COLOR -> no score_valid; all outputs 0; the next submit scores normally with tries=1.
6. With MASTERMIND_TRY_LIMIT_EN and MAX_TRIES=3: three non-winning submits -> game_over=1 after the third DONE; a 4th submit is ignored; new_game clears game_over and sets tries=0.
